// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// fetch against instruction memory, and fills the IF/ID segment register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc,
    input  logic        flush,
    input  logic        stall,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_add4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_kill;
    logic [31:0] r_pc;
    logic [31:0] r_skid;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_kill     <= 1'b0;
            r_pc       <= RESET_PC;
            r_skid     <= '0;
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
        end else if (flush) begin
            // Redirect wins over stall; a granted-but-unreturned fetch is marked for discard.
            r_pc       <= npc;
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                        r_kill  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end else begin
            if (!stall) begin
                r_id_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end else if (!stall) begin
                            r_id_valid <= 1'b1;
                            r_id_pc    <= r_pc;
                            r_id_inst  <= imem_rdata;
                            r_pc       <= npc;
                            r_state    <= S_REQ;
                            r_req      <= 1'b1;
                        end else begin
                            // ID is stalled: park the word until IF/ID can take it.
                            r_skid  <= imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_id_valid <= 1'b1;
                        r_id_pc    <= r_pc;
                        r_id_inst  <= r_skid;
                        r_pc       <= npc;
                        r_state    <= S_REQ;
                        r_req      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign if_pc      = r_pc;
    assign if_pc_add4 = r_pc + 32'd4;
    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign id_valid   = r_id_valid;
    assign id_pc      = r_id_pc;
    assign id_inst    = r_id_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized stall/flush
// traffic, checked against an in-order instruction-stream model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] npc;
    logic [31:0] if_pc;
    logic [31:0] if_pc_add4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks = 0;
    int failures = 0;

    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          cnt = 0;

    logic [31:0] exp_pc = RESET_PC;
    int          ndeliv = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .npc         (npc),
        .flush       (flush),
        .stall       (stall),
        .if_pc       (if_pc),
        .if_pc_add4  (if_pc_add4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    always #5 clk = ~clk;

    // Next-PC mux stand-in: sequential unless redirecting.
    assign npc = flush ? tgt : if_pc_add4;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    // Instruction memory, reset on the same rstn; drives on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            pend        = 1'b0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_at(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (imem_req && (int'($urandom_range(99)) < gnt_pct)) begin
                imem_gnt = 1'b1;
                paddr    = imem_addr;
                pend     = 1'b1;
                cnt      = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the rising edge, then check what IF/ID must show.
    task automatic tick();
        logic        s, f, r, ov;
        logic [31:0] t, opc, oin;
        s = stall; f = flush; t = tgt; r = rstn;
        ov = id_valid; opc = id_pc; oin = id_inst;
        @(negedge clk);
        #1;
        if (!r) begin
            chk("m_rst_pc", if_pc, RESET_PC);
            chk("m_rst_valid", 32'(id_valid), 32'd0);
            exp_pc = RESET_PC;
        end else if (f) begin
            chk("m_flush_valid", 32'(id_valid), 32'd0);
            chk("m_flush_inst", id_inst, NOP);
            chk("m_flush_pc", if_pc, t);
            exp_pc = t;
        end else if (s) begin
            chk("m_stall_valid", 32'(id_valid), 32'(ov));
            chk("m_stall_pc", id_pc, opc);
            chk("m_stall_inst", id_inst, oin);
        end else if (id_valid) begin
            chk("m_deliv_pc", id_pc, exp_pc);
            chk("m_deliv_inst", id_inst, word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            ndeliv++;
        end
    endtask

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] hold_idpc;
        int          base;

        // Reset values, then in-order fetch with single-cycle memory.
        tick();
        tick();
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_req", 32'(imem_req), 32'd0);
        rstn = 1'b1;
        tick();
        chk("f0_req", 32'(imem_req), 32'd1);
        chk("f0_addr", imem_addr, RESET_PC);
        tick();
        chk("f0_wait_req", 32'(imem_req), 32'd0);
        tick();
        chk("d0_valid", 32'(id_valid), 32'd1);
        chk("d0_pc", id_pc, RESET_PC);
        chk("f1_addr", imem_addr, RESET_PC + 32'd4);
        tick();
        chk("d0_bubble", 32'(id_valid), 32'd0);
        tick();
        chk("d1_pc", id_pc, RESET_PC + 32'd4);
        chk("f2_addr", imem_addr, RESET_PC + 32'd8);

        // Stall across a returning word.
        for (int k = 0; k < 20 && !imem_rvalid; k++) tick();
        chk("s2_rvalid_seen", 32'(imem_rvalid), 32'd1);
        hold_pc   = if_pc;
        hold_idpc = id_pc;
        stall = 1'b1;
        tick();
        tick();
        tick();
        chk("s2_hold_pc", if_pc, hold_pc);
        chk("s2_hold_idpc", id_pc, hold_idpc);
        chk("s2_hold_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        tick();
        chk("s2_rel_valid", 32'(id_valid), 32'd1);
        chk("s2_rel_inst", id_inst, word_at(hold_pc));
        chk("s2_rel_pc", if_pc, hold_pc + 32'd4);
        tick();
        chk("s2_pc_once", if_pc, hold_pc + 32'd4);

        // Flush while waiting for a slow response.
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 20 && !imem_gnt; k++) tick();
        chk("s3_gnt_seen", 32'(imem_gnt), 32'd1);
        tick();
        flush = 1'b1;
        tgt   = 32'h0040_0100;
        tick();
        flush = 1'b0;
        chk("s3_flush_pc", if_pc, 32'h0040_0100);
        tick();
        chk("s3_kill_v0", 32'(id_valid), 32'd0);
        tick();
        chk("s3_kill_v1", 32'(id_valid), 32'd0);
        chk("s3_req", 32'(imem_req), 32'd1);
        chk("s3_addr", imem_addr, 32'h0040_0100);

        // Flush in the same cycle as the grant.
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 20 && !(imem_req && imem_gnt); k++) tick();
        chk("s4_gnt_now", 32'(imem_gnt), 32'd1);
        flush = 1'b1;
        tgt   = 32'h0040_0200;
        tick();
        flush = 1'b0;
        chk("s4_flush_pc", if_pc, 32'h0040_0200);
        for (int k = 0; k < 20 && !(imem_req && imem_gnt); k++) tick();
        chk("s4_regnt", 32'(imem_gnt), 32'd1);
        chk("s4_addr", imem_addr, 32'h0040_0200);
        chk("s4_discard", 32'(id_valid), 32'd0);
        tick();
        tick();
        chk("s4_deliv_v", 32'(id_valid), 32'd1);
        chk("s4_deliv_pc", id_pc, 32'h0040_0200);

        // Flush and stall together with a live IF/ID.
        flush = 1'b1;
        stall = 1'b1;
        tgt   = 32'h0040_0300;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        chk("s5_valid", 32'(id_valid), 32'd0);
        chk("s5_inst", id_inst, NOP);
        chk("s5_pc", if_pc, 32'h0040_0300);

        // PC wrap, then asynchronous reset in the middle of a wait.
        flush = 1'b1;
        tgt   = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        chk("s6_pc", if_pc, 32'hFFFF_FFFC);
        chk("s6_add4", if_pc_add4, 32'h0000_0000);
        for (int k = 0; k < 10; k++) tick();
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 20 && !imem_gnt; k++) tick();
        chk("s6_gnt_seen", 32'(imem_gnt), 32'd1);
        tick();
        #1 rstn = 1'b0;
        #1;
        chk("s6_async_pc", if_pc, RESET_PC);
        chk("s6_async_valid", 32'(id_valid), 32'd0);
        chk("s6_async_req", 32'(imem_req), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("s6_restart_addr", imem_addr, RESET_PC);
        for (int k = 0; k < 12; k++) tick();

        // Randomized traffic against the stream model.
        gnt_pct = 60;
        lat_min = 1;
        lat_max = 3;
        base = ndeliv;
        for (int k = 0; k < 1500; k++) begin
            stall = (int'($urandom_range(99)) < 25);
            flush = (int'($urandom_range(99)) < 4);
            tgt   = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        stall = 1'b0;
        flush = 1'b0;
        tick();
        chk("rand_progress", 32'((ndeliv - base) > 40), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the PC register and drives instruction memory through a req/gnt/rvalid handshake.
- Fills the IF/ID segment register.
- Consumes the next-PC mux outputs: npc, and flush as the redirect/kill command. Supplies pc_add4 back to that mux.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0013, id_inst value at reset and on flush.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- npc  input  32  next PC from the next-PC mux; sampled only on PC-update cycles.
- flush  input  1  redirect: npc is a branch/jump target; kill the wrong-path fetch.
- stall  input  1  ID hazard stall: hold IF/ID and the PC.
- if_pc  output  32  current PC register.
- if_pc_add4  output  32  if_pc + 4, combinational, modulo 2^32.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, equals if_pc.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; at earliest one cycle after gnt.
- imem_rdata  input  32  instruction word.
- id_valid  output  1  IF/ID holds a live instruction.
- id_pc  output  32  IF/ID PC.
- id_inst  output  32  IF/ID instruction.

Behaviour:
- Reset (asynchronous, rstn=0):
  - pc = RESET_PC; state = S_IDLE; kill = 0.
  - id_valid = 0, id_pc = 0, id_inst = NOP_INST.
  - Skid buffer cleared; imem_req = 0.
- At most one outstanding fetch. imem_req = 1 only in S_REQ. imem_addr = pc.
- States:
  - S_IDLE: go to S_REQ on the next clock.
  - S_REQ: on imem_gnt, go to S_WAIT.
  - S_WAIT: wait for imem_rvalid.
    - rvalid && kill: discard the data, clear kill, go to S_REQ.
    - rvalid && !kill && !stall: load IF/ID (valid=1, pc=pc, inst=rdata), pc <= npc, go to S_REQ.
    - rvalid && !kill && stall: capture rdata into the skid buffer, go to S_HOLD.
  - S_HOLD: when stall drops, load IF/ID from the buffer, pc <= npc, go to S_REQ.
- IF/ID update rules:
  - stall=1 and flush=0: IF/ID holds.
  - stall=0 and no instruction delivered this cycle: id_valid <= 0 (bubble); id_pc and id_inst hold.
- flush=1 takes priority over stall in every state:
  - id_valid <= 0, id_inst <= NOP_INST, pc <= npc.
  - S_REQ, gnt=0: stay in S_REQ; the address changes to the new pc. Memory samples imem_addr only in the gnt cycle.
  - S_REQ, gnt=1 in the same cycle: go to S_WAIT with kill=1, because the granted fetch is wrong-path.
  - S_WAIT, rvalid=0: set kill=1, stay in S_WAIT.
  - S_WAIT, rvalid=1 in the same cycle: discard the data, go to S_REQ, kill=0.
  - S_HOLD: drop the buffer, go to S_REQ.
  - S_IDLE: pc <= npc only.
- npc is sampled only on PC-update cycles (accept, or flush); at all other times pc holds.
- Latency: minimum 2 cycles per instruction (req+gnt, then rvalid). The IF/ID register updates on the rvalid clock edge.
- Arithmetic: pc + 4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Reset asserted mid-transaction: an in-flight response after reset release is ignored, because the state returns to S_IDLE and memory is reset on the same rstn.

Test Plan:
- Reset release, memory gnt same cycle, rvalid next cycle, npc tied to if_pc_add4 -> fetch addresses 0x00400000, 0x00400004, 0x00400008; id_pc follows with id_valid=1 every 2nd cycle and 0 in between.
- stall=1 for 3 cycles during an rvalid -> instruction held in S_HOLD; IF/ID unchanged. On release, id_inst = buffered word and if_pc advances by 4 exactly once.
- flush=1 with npc=0x00400100 while in S_WAIT, rvalid two cycles later -> response discarded (id_valid stays 0); next imem_addr = 0x00400100.
- flush and gnt in the same cycle in S_REQ -> the following rvalid is discarded; next request goes to npc.
- flush and stall both high with IF/ID valid -> id_valid=0, id_inst=0x00000013, pc=npc.
- pc=0xFFFFFFFC -> if_pc_add4=0x00000000; rstn pulsed low mid-S_WAIT -> pc=0x00400000 and id_valid=0 immediately, without a clock edge.
